// File: rtl/spm_ctrl.sv
// spm_ctrl: sequencer for a serial-parallel multiplier.
// Accepts a signed operand pair, streams the multiplier LSB first and
// reassembles the 2*size-bit signed product from the serial result.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   in_valid/in_ready         operand handshake (x_in, y_in)
//   spm_rst, spm_x, spm_y     drive to the serial multiplier
//   spm_p                     serial product bit back from the multiplier
//   prod, out_valid/out_ready result handshake
module spm_ctrl #(
  parameter int size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [size-1:0]     x_in,
  input  logic [size-1:0]     y_in,
  output logic                spm_rst,
  output logic [size-1:0]     spm_x,
  output logic                spm_y,
  input  logic                spm_p,
  output logic [2*size-1:0]   prod,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CW = $clog2(2*size+1);
  localparam logic [CW-1:0] LAST = CW'(2*size);
  localparam logic [CW-1:0] YTOP = CW'(size);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [size-1:0]     xreg_q, xreg_d;
  logic [size-1:0]     yreg_q, yreg_d;
  logic [2*size-1:0]   prod_q, prod_d;
  logic [size-1:0]     y_shift;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign spm_rst   = (state_q == IDLE);
  assign spm_x     = xreg_q;
  assign prod      = prod_q;

  // Beyond the top operand bit the multiplier keeps seeing the sign bit.
  assign y_shift = yreg_q >> cnt_q;
  assign spm_y   = (cnt_q < YTOP) ? y_shift[0] : yreg_q[size-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xreg_d  = xreg_q;
    yreg_d  = yreg_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          xreg_d  = x_in;
          yreg_d  = y_in;
          cnt_d   = '0;
          prod_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The multiplier output is registered: bit c arrives at cnt c+1.
        if (cnt_q != '0) begin
          prod_d = {spm_p, prod_q[2*size-1:1]};
        end
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xreg_q  <= '0;
      yreg_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xreg_q  <= xreg_d;
      yreg_q  <= yreg_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_spm_ctrl.sv
// tb_spm_ctrl: random and directed checks of spm_ctrl (size=4)
// against a behavioural serial multiplier and x*y reference.
module tb_spm_ctrl;

  localparam int SZ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SZ-1:0]   x_in;
  logic [SZ-1:0]   y_in;
  logic            spm_rst;
  logic [SZ-1:0]   spm_x;
  logic            spm_y;
  logic            spm_p;
  logic [2*SZ-1:0] prod;
  logic            out_valid;
  logic            out_ready;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spm_ctrl #(.size(SZ)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x_in(x_in),
    .y_in(y_in),
    .spm_rst(spm_rst),
    .spm_x(spm_x),
    .spm_y(spm_y),
    .spm_p(spm_p),
    .prod(prod),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Serial multiplier: after seeing y bits 0..k, the low k+1 bits of
  // x * (bits so far) are final; emit bit k one cycle later.
  longint unsigned yacc = 0;
  int              k    = 0;
  always @(posedge clk) begin
    longint xs;
    longint pr;
    if (spm_rst === 1'b1) begin
      k    = 0;
      yacc = 0;
      spm_p <= 1'b0;
    end else if (spm_rst === 1'b0) begin
      if (k < 48) begin
        yacc = yacc | (longint'(spm_y) << k);
        xs   = longint'($signed(spm_x));
        pr   = xs * longint'(yacc);
        spm_p <= pr[k];
        k++;
      end
    end
  end

  function automatic logic [2*SZ-1:0] ref_mul(logic [SZ-1:0] a,
                                              logic [SZ-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return (2*SZ)'(sa * sb);
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(logic [SZ-1:0] x, logic [SZ-1:0] y, int hold);
    logic [2*SZ-1:0] exp;
    int n;
    exp = ref_mul(x, y);
    @(negedge clk);
    chk("idle_rdy", in_ready, 1);
    in_valid  = 1'b1;
    x_in      = x;
    y_in      = y;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("acc_prod0", prod, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom);
      x_in     = SZ'($urandom);
      y_in     = SZ'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, 2*SZ+1);
    chk("prod", prod, exp);
    chk("spm_x", spm_x, x);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_prod", prod, exp);
      chk("hold_ov", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ret_idle", in_ready, 1);
    chk("ret_ov", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int last;
    int seen;
    logic [2*SZ-1:0] q[$];
    rst       = 1'b0;
    in_valid  = 1'b0;
    x_in      = '0;
    y_in      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_spmrst", spm_rst, 1);
    chk("rst_y", spm_y, 0);
    chk("rst_x", spm_x, 0);
    chk("rst_prod", prod, 0);
    @(negedge clk);
    rst = 1'b1;

    do_op(4'h3, 4'h5, 0);
    do_op(4'hD, 4'h5, 0);
    do_op(4'h8, 4'h8, 1);
    do_op(4'h7, 4'hF, 5);

    // Abort mid-shift.
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 4'h5;
    y_in     = 4'h7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_rdy", in_ready, 1);
    chk("abort_prod", prod, 0);
    chk("abort_spmrst", spm_rst, 1);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort_noov", seen, 0);
    do_op(4'h2, 4'h3, 0);

    for (int i = 0; i < 30; i++) begin
      do_op(SZ'($urandom), SZ'($urandom), $urandom_range(0, 3));
    end

    // Back-to-back with in_valid held high.
    last = -1;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      x_in      = SZ'($urandom);
      y_in      = SZ'($urandom);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      if (out_valid) begin
        if (q.size() > 0) chk("b2b_prod", prod, q.pop_front());
        else chk("b2b_extra", 1, 0);
      end
      if (in_ready) begin
        q.push_back(ref_mul(x_in, y_in));
        if (last >= 0) chk("b2b_gap", i - last, 2*SZ+3);
        last = i;
        seen++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", seen >= 6, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
